// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: pause/clear/RAM select levels and FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic PAUSE_ENABLE  = 1'b1;
  localparam logic PAUSE_DISABLE = 1'b0;
  localparam logic CLEAR_ENABLE  = 1'b1;
  localparam logic CLEAR_DISABLE = 1'b0;
  localparam logic RAM_SEL_INST  = 1'b0;
  localparam logic RAM_SEL_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DMEM    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags when the ID instruction reads a register that the EX-stage load writes.
module pipe_hazard_ctrl_load_use_detect #(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rt_used,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  output logic              hazard
);

  // Register 0 is hard-wired, so a load targeting it never needs a bubble.
  assign hazard = ex_mem_read && (ex_rd_addr != '0) &&
                  ((id_rs_used && (id_rs_addr == ex_rd_addr)) ||
                   (id_rt_used && (id_rt_addr == ex_rd_addr)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller and shared-RAM arbiter for the 5-stage pipeline.
// Optional statistics counters are enabled with the HAZARD_STAT_EN macro.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int RAM_WAIT = 2
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rt_used,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_branch_taken,
  input  logic              mem_ram_req,
  output logic              pc_pause,
  output logic              if_id_pause,
  output logic              if_id_clear,
  output logic              id_ex_pause,
  output logic              id_ex_clear,
  output logic              ex_mem_pause,
  output logic              ram_sel,
  output logic              mem_data_latch
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       load_use;

  pipe_hazard_ctrl_load_use_detect #(.REG_AW(REG_AW)) u_load_use (
    .id_rs_addr  (id_rs_addr),
    .id_rs_used  (id_rs_used),
    .id_rt_addr  (id_rt_addr),
    .id_rt_used  (id_rt_used),
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .hazard      (load_use)
  );

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    pc_pause       = PAUSE_DISABLE;
    if_id_pause    = PAUSE_DISABLE;
    id_ex_pause    = PAUSE_DISABLE;
    ex_mem_pause   = PAUSE_DISABLE;
    if_id_clear    = CLEAR_DISABLE;
    id_ex_clear    = CLEAR_DISABLE;
    ram_sel        = RAM_SEL_INST;
    mem_data_latch = 1'b0;

    unique case (state)
      S_RUN: begin
        if (mem_ram_req) begin
          ram_sel      = RAM_SEL_DATA;
          pc_pause     = PAUSE_ENABLE;
          if_id_pause  = PAUSE_ENABLE;
          id_ex_pause  = PAUSE_ENABLE;
          ex_mem_pause = PAUSE_ENABLE;
          wait_cnt_nxt = WAIT_INIT;
          if (RAM_WAIT == 1) begin
            mem_data_latch = 1'b1;
            state_nxt      = S_RELEASE;
          end else begin
            state_nxt = S_DMEM;
          end
        end else if (ex_branch_taken) begin
          if_id_clear = CLEAR_ENABLE;
          id_ex_clear = CLEAR_ENABLE;
        end else if (load_use) begin
          pc_pause    = PAUSE_ENABLE;
          if_id_pause = PAUSE_ENABLE;
          id_ex_clear = CLEAR_ENABLE;
        end
      end

      S_DMEM: begin
        ram_sel      = RAM_SEL_DATA;
        pc_pause     = PAUSE_ENABLE;
        if_id_pause  = PAUSE_ENABLE;
        id_ex_pause  = PAUSE_ENABLE;
        ex_mem_pause = PAUSE_ENABLE;
        wait_cnt_nxt = 4'(wait_cnt - 4'd1);
        if (wait_cnt == 4'd1) begin
          mem_data_latch = 1'b1;
          state_nxt      = S_RELEASE;
        end
      end

      // The pending request was already served; give fetch one cycle before any new access.
      S_RELEASE: begin
        state_nxt = S_RUN;
        if (ex_branch_taken) begin
          if_id_clear = CLEAR_ENABLE;
          id_ex_clear = CLEAR_ENABLE;
        end else if (load_use) begin
          pc_pause    = PAUSE_ENABLE;
          if_id_pause = PAUSE_ENABLE;
          id_ex_clear = CLEAR_ENABLE;
        end
      end

      default: state_nxt = S_RUN;
    endcase
  end

`ifdef HAZARD_STAT_EN
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (pc_pause)    stall_cycles <= stall_cycles + 32'd1;
      if (if_id_clear) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table vectors in S_RUN plus RAM freeze/reset sequences.
// Two instances share the inputs: RAM_WAIT=3 (dut3) and RAM_WAIT=2 (dut2).
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [3:0] rs;
    logic       rs_used;
    logic [3:0] rt;
    logic       rt_used;
    logic       mem_read;
    logic [3:0] rd;
    logic       br;
    logic       req;
  } in_t;

  typedef struct packed {
    logic       which;
    logic [7:0] exp;
  } sb_t;

  typedef struct packed {
    in_t        stim;
    logic [7:0] exp;
  } vec_t;

  // Output bit order: pc_pause, if_id_pause, if_id_clear, id_ex_pause,
  // id_ex_clear, ex_mem_pause, ram_sel, mem_data_latch
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_1000;
  localparam logic [7:0] O_BR   = 8'b0010_1000;
  localparam logic [7:0] O_FRZ  = 8'b1101_0110;
  localparam logic [7:0] O_FRZL = 8'b1101_0111;
  localparam logic       D3 = 1'b0;
  localparam logic       D2 = 1'b1;

  logic       clk_50MHz = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] id_rs_addr = '0, id_rt_addr = '0, ex_rd_addr = '0;
  logic       id_rs_used = 0, id_rt_used = 0, ex_mem_read = 0;
  logic       ex_branch_taken = 0, mem_ram_req = 0;

  logic [7:0] out3, out2;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall3, flush3, stall2, flush2;
`endif

  int  total = 0;
  int  bad   = 0;
  sb_t sb_q[$];

  always #5 clk_50MHz = ~clk_50MHz;

  pipe_hazard_ctrl #(.REG_AW(4), .RAM_WAIT(3)) dut3 (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_ram_req(mem_ram_req),
    .pc_pause(out3[7]), .if_id_pause(out3[6]), .if_id_clear(out3[5]),
    .id_ex_pause(out3[4]), .id_ex_clear(out3[3]), .ex_mem_pause(out3[2]),
    .ram_sel(out3[1]), .mem_data_latch(out3[0])
`ifdef HAZARD_STAT_EN
    , .stall_cycles(stall3), .flush_count(flush3)
`endif
  );

  pipe_hazard_ctrl #(.REG_AW(4), .RAM_WAIT(2)) dut2 (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_ram_req(mem_ram_req),
    .pc_pause(out2[7]), .if_id_pause(out2[6]), .if_id_clear(out2[5]),
    .id_ex_pause(out2[4]), .id_ex_clear(out2[3]), .ex_mem_pause(out2[2]),
    .ram_sel(out2[1]), .mem_data_latch(out2[0])
`ifdef HAZARD_STAT_EN
    , .stall_cycles(stall2), .flush_count(flush2)
`endif
  );

  task automatic driveInputs(input in_t v);
    id_rs_addr      = v.rs;
    id_rs_used      = v.rs_used;
    id_rt_addr      = v.rt;
    id_rt_used      = v.rt_used;
    ex_mem_read     = v.mem_read;
    ex_rd_addr      = v.rd;
    ex_branch_taken = v.br;
    mem_ram_req     = v.req;
  endtask

  task automatic applyStimulus(input in_t v, input logic [7:0] exp, input logic which);
    sb_t e;
    @(negedge clk_50MHz);
    driveInputs(v);
    e.which = which;
    e.exp   = exp;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    sb_t        e;
    logic [7:0] act;
    #2;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s scoreboard empty", name);
    end else begin
      e   = sb_q.pop_front();
      act = (e.which == D2) ? out2 : out3;
      if (act !== e.exp) begin
        bad++;
        $display("[TB] FAIL %s got=%b want=%b", name, act, e.exp);
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk_50MHz);
    driveInputs('0);
    rst = 1'b1;
    @(negedge clk_50MHz);
    @(negedge clk_50MHz);
    rst = 1'b0;
  endtask

  function automatic in_t mk(input logic [3:0] rs, input logic rsu, input logic [3:0] rt,
                             input logic rtu, input logic mr, input logic [3:0] rd,
                             input logic br, input logic req);
    in_t v;
    v.rs = rs; v.rs_used = rsu; v.rt = rt; v.rt_used = rtu;
    v.mem_read = mr; v.rd = rd; v.br = br; v.req = req;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = '{stim: mk(0, 0, 0, 0, 0, 0, 0, 0), exp: O_NONE};
    vecs[1] = '{stim: mk(5, 1, 0, 0, 1, 5, 0, 0), exp: O_LU};
    vecs[2] = '{stim: mk(0, 1, 0, 1, 1, 0, 0, 0), exp: O_NONE};
    vecs[3] = '{stim: mk(2, 1, 7, 1, 1, 7, 0, 0), exp: O_LU};
    vecs[4] = '{stim: mk(2, 1, 7, 0, 1, 7, 0, 0), exp: O_NONE};
    vecs[5] = '{stim: mk(5, 1, 0, 0, 0, 5, 0, 0), exp: O_NONE};
    vecs[6] = '{stim: mk(0, 0, 0, 0, 0, 0, 1, 0), exp: O_BR};
    vecs[7] = '{stim: mk(5, 1, 0, 0, 1, 5, 1, 0), exp: O_BR};
    vecs[8] = '{stim: mk(4, 1, 3, 1, 1, 5, 0, 0), exp: O_NONE};
    vecs[9] = '{stim: mk(0, 0, 0, 0, 0, 0, 0, 0), exp: O_NONE};

    $display("[TB] start");
    doReset();
    applyStimulus('0, O_NONE, D3); checkOutput("reset_dut3");
    applyStimulus('0, O_NONE, D2); checkOutput("reset_dut2");

    // Single-cycle hazard vectors; mem_ram_req stays low so the FSM stays in S_RUN
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].stim, vecs[i].exp, D3);
      checkOutput($sformatf("vec%0d", i));
    end
`ifdef HAZARD_STAT_EN
    @(negedge clk_50MHz);
    checkValue("stat_stall_after_table", stall3, 32'd2);
    checkValue("stat_flush_after_table", flush3, 32'd2);
`endif

    // Back-to-back accesses with RAM_WAIT=3 and the request held high
    doReset();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), O_FRZ,  D3); checkOutput("b2b_c1");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), O_FRZ,  D3); checkOutput("b2b_c2");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), O_FRZL, D3); checkOutput("b2b_c3_latch");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), O_NONE, D3); checkOutput("b2b_release");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), O_FRZ,  D3); checkOutput("b2b_second_c1");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), O_FRZ,  D3); checkOutput("b2b_second_c2");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), O_FRZL, D3); checkOutput("b2b_second_c3");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), O_NONE, D3); checkOutput("b2b_second_rel");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), O_NONE, D3); checkOutput("b2b_idle");

    // RAM_WAIT=2 with branch held: branch is frozen out, then flushes in S_RELEASE
    doReset();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1), O_FRZ,  D2); checkOutput("br_mem_c1");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1), O_FRZL, D2); checkOutput("br_mem_c2_latch");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1), O_BR,   D2); checkOutput("br_mem_release");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1), O_FRZ,  D2); checkOutput("br_mem_next_c1");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), O_FRZL, D2); checkOutput("br_mem_next_c2");
    applyStimulus(mk(5, 1, 0, 0, 1, 5, 0, 0), O_LU,   D2); checkOutput("release_loaduse");

    // Reset pulse in the 2nd cycle of a RAM_WAIT=3 access abandons it
    doReset();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), O_FRZ, D3); checkOutput("rst_mid_c1");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), O_FRZ, D3); checkOutput("rst_mid_c2");
    rst = 1'b1;
    driveInputs('0);
    sb_q.push_back('{which: D3, exp: O_NONE});
    checkOutput("rst_mid_immediate");
    @(negedge clk_50MHz);
    rst = 1'b0;
    applyStimulus('0, O_NONE, D3); checkOutput("rst_mid_no_latch1");
    applyStimulus('0, O_NONE, D3); checkOutput("rst_mid_no_latch2");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), O_FRZ,  D3); checkOutput("rst_new_c1");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), O_FRZ,  D3); checkOutput("rst_new_c2");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), O_FRZL, D3); checkOutput("rst_new_c3");
`ifdef HAZARD_STAT_EN
    doReset();
    @(negedge clk_50MHz);
    checkValue("stat_stall_after_reset", stall3, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
